hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the enable, flush and bubble inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, taken branches and data-memory wait. Selects ID-stage operand forwarding.
- Sits beside the decode stage. Consumes the register-address and write-control outputs of the ID/EX and EX/MEM registers.
- Contains a state machine, a wait/timeout counter and a saturating stall-cycle counter.

Parameters:
- RA_W, 4, register-address width.
- TIMEOUT, 15, maximum consecutive dm_busy cycles before abort.
- CNT_W, 16, stall performance counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- id_RA  in  RA_W  source A address of the instruction in ID.
- id_RB  in  RA_W  source B address of the instruction in ID.
- id_use_RA  in  1  instruction in ID reads RA.
- id_use_RB  in  1  instruction in ID reads RB.
- ex_WC  in  RA_W  destination register of the instruction in EX.
- ex_W_RB  in  1  instruction in EX writes the register bank.
- ex_S_MXRB  in  2  write-back source select of the instruction in EX.
- mem_WC  in  RA_W  destination register of the instruction in MEM.
- mem_W_RB  in  1  instruction in MEM writes the register bank.
- br_taken  in  1  branch resolved taken in EX.
- dm_busy  in  1  data memory not ready.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_en  out  1  ID/EX register enable.
- idex_bubble  out  1  load passb/no-write control into ID/EX.
- exmem_en  out  1  EX/MEM register enable.
- fwd_A  out  2  operand A source: 00 register file, 01 EX result, 10 MEM result.
- fwd_B  out  2  operand B source, same encoding as fwd_A.
- err_timeout  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (RESET=1, asynchronous):
  - state=RUN, wait_cnt=0, stall_cnt=0, err_timeout=0.
  - While RESET is high, all enables are 0, ifid_flush=1, idex_bubble=1, fwd_A=fwd_B=00.
- Outputs are combinational from state and inputs. state, wait_cnt, stall_cnt and err_timeout are registered.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_W_RB=1 and ex_S_MXRB==MXRB_MEM;
  - (id_use_RA and id_RA==ex_WC) or (id_use_RB and id_RB==ex_WC).
  - No register is hardwired; address 0 is compared like any other.
- State RUN, priority dm_busy > br_taken > lu:
  - dm_busy: all enables 0; next=MEM_WAIT; wait_cnt=1.
  - br_taken: all enables 1; ifid_flush=1; idex_bubble=1. Squashes 2 younger instructions; PC loads the target. Stay in RUN.
  - lu: pc_en=0, ifid_en=0; idex_en=1, idex_bubble=1, exmem_en=1; next=LOAD_STALL.
  - Otherwise: all enables 1, no flush or bubble.
- State LOAD_STALL (exactly 1 cycle):
  - All enables 1; lu detection is suppressed.
  - dm_busy has priority: next=MEM_WAIT. Otherwise next=RUN.
  - br_taken is handled exactly as in RUN.
- State MEM_WAIT:
  - All enables 0; wait_cnt increments each cycle.
  - dm_busy=0: next=RUN; wait_cnt=0. The resume cycle follows the RUN rules.
  - wait_cnt==TIMEOUT with dm_busy still 1: err_timeout<=1 (sticky until RESET); next=RUN; wait_cnt=0 (abort).
  - dm_busy falling in the same cycle that wait_cnt hits TIMEOUT is a normal exit; no error.
- stall_cnt:
  - Increments in every cycle where pc_en=0 and RESET=0.
  - Saturates at all-ones with no wrap.
- Forwarding, per operand X∈{A,B}:
  - 01 if ex_W_RB and ex_WC==id_RX and ex_S_MXRB!=MXRB_MEM.
  - else 10 if mem_W_RB and mem_WC==id_RX.
  - else 00.
  - EX beats MEM. A load in EX never forwards; it is handled by lu.
- Reset mid-MEM_WAIT or mid-LOAD_STALL returns the unit to RUN immediately.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding: RUN=2'd0, LOAD_STALL=2'd1, MEM_WAIT=2'd2;
  - MXRB_MEM=2'b01;
  - FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10;
  - NOP_OP_ALU=5'b10011 (passb).
- One sub-module, fwd_sel: a pure combinational comparator instantiated twice, for A and B.

Test Plan:
- Load r3 in EX (ex_S_MXRB=01, ex_W_RB=1, ex_WC=3), ID reads id_RA=3 -> pc_en=0, ifid_en=0, idex_bubble=1 for one cycle, then all enables 1; stall_cnt=1.
- ALU write r5 in EX, id_RB=5 also in MEM -> fwd_B=01; with ex_W_RB=0 -> fwd_B=10.
- br_taken=1 together with lu active -> ifid_flush=1, idex_bubble=1, pc_en=1, state stays RUN.
- dm_busy high for 4 cycles -> all enables 0 for 4 cycles, stall_cnt=4, err_timeout=0.
- dm_busy held 20 cycles (TIMEOUT=15) -> err_timeout=1 after cycle 15, state RUN, flag stays set until RESET.
- RESET pulsed during MEM_WAIT -> state RUN, counters 0, flush/bubble asserted while RESET high.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, write-back and
// forwarding select codes, and the passb opcode used for bubbles.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0] MXRB_MEM   = 2'b01;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EX     = 2'b01;
  localparam logic [1:0] FWD_MEM    = 2'b10;

  localparam logic [4:0] NOP_OP_ALU = 5'b10011;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding comparator for one ID-stage source register.
// A load sitting in EX never forwards; the load-use stall covers it.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int RA_W = 4
) (
  input  logic [RA_W-1:0] id_r,
  input  logic [RA_W-1:0] ex_WC,
  input  logic            ex_W_RB,
  input  logic [1:0]      ex_S_MXRB,
  input  logic [RA_W-1:0] mem_WC,
  input  logic            mem_W_RB,
  output logic [1:0]      fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (ex_W_RB && (ex_WC == id_r) && (ex_S_MXRB != MXRB_MEM))
      fwd = FWD_EX;
    else if (mem_W_RB && (mem_WC == id_r))
      fwd = FWD_MEM;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch squash, data-memory wait
// with timeout abort, ID-stage forwarding and a saturating stall counter.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W    = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [RA_W-1:0]  id_RA,
  input  logic [RA_W-1:0]  id_RB,
  input  logic             id_use_RA,
  input  logic             id_use_RB,
  input  logic [RA_W-1:0]  ex_WC,
  input  logic             ex_W_RB,
  input  logic [1:0]       ex_S_MXRB,
  input  logic [RA_W-1:0]  mem_WC,
  input  logic             mem_W_RB,
  input  logic             br_taken,
  input  logic             dm_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  state_t          state, state_nx;
  logic [WC_W-1:0] wait_cnt, wait_nx;
  logic            err_nx;
  logic            lu, lu_ok;
  logic [1:0]      fwd_a_raw, fwd_b_raw;

  assign lu = ex_W_RB && (ex_S_MXRB == MXRB_MEM) &&
              ((id_use_RA && (id_RA == ex_WC)) || (id_use_RB && (id_RB == ex_WC)));
  // The instruction that caused a load stall is re-examined once; suppress it.
  assign lu_ok = lu && (state != LOAD_STALL);

  fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .id_r(id_RA), .ex_WC(ex_WC), .ex_W_RB(ex_W_RB), .ex_S_MXRB(ex_S_MXRB),
    .mem_WC(mem_WC), .mem_W_RB(mem_W_RB), .fwd(fwd_a_raw)
  );

  fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .id_r(id_RB), .ex_WC(ex_WC), .ex_W_RB(ex_W_RB), .ex_S_MXRB(ex_S_MXRB),
    .mem_WC(mem_WC), .mem_W_RB(mem_W_RB), .fwd(fwd_b_raw)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= RUN;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_nx;
      err_timeout <= err_nx;
    end
  end

  // A non-busy MEM_WAIT cycle is the resume cycle and follows the RUN rules.
  always_comb begin
    state_nx = RUN;
    wait_nx  = '0;
    err_nx   = err_timeout;
    if ((state == MEM_WAIT) && dm_busy) begin
      if (wait_cnt == WC_W'(TIMEOUT)) begin
        err_nx = 1'b1;
      end else begin
        state_nx = MEM_WAIT;
        wait_nx  = wait_cnt + WC_W'(1);
      end
    end else if (dm_busy) begin
      state_nx = MEM_WAIT;
      wait_nx  = WC_W'(1);
    end else if (br_taken) begin
      state_nx = RUN;
    end else if (lu_ok) begin
      state_nx = LOAD_STALL;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    fwd_A       = fwd_a_raw;
    fwd_B       = fwd_b_raw;
    if (RESET) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fwd_A       = FWD_RF;
      fwd_B       = FWD_RF;
    end else if (dm_busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu_ok) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      stall_cnt <= '0;
    else if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle model feeding an expected-output queue.
module tb_hazard_ctrl;

  localparam int RA_W    = 4;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 5;
  localparam logic [CNT_W-1:0] SAT = '1;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [RA_W-1:0]  id_RA, id_RB, ex_WC, mem_WC;
  logic             id_use_RA, id_use_RB, ex_W_RB, mem_W_RB, br_taken, dm_busy;
  logic [1:0]       ex_S_MXRB;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en;
  logic [1:0]       fwd_A, fwd_B;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct packed {
    logic [3:0] ra, rb;
    logic       ua, ub;
    logic [3:0] ex_wc;
    logic       ex_w;
    logic [1:0] ex_s;
    logic [3:0] mem_wc;
    logic       mem_w, br, busy;
  } in_t;

  typedef struct packed {
    logic             pc, ifid, flush, idex, bubble, exmem;
    logic [1:0]       fa, fb;
    logic             err;
    logic [CNT_W-1:0] stall;
  } out_t;

  in_t  cur;
  out_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  int               m_state = 0;
  int               m_wait = 0;
  logic             m_err = 1'b0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] base;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.RA_W(RA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .id_RA(id_RA), .id_RB(id_RB), .id_use_RA(id_use_RA), .id_use_RB(id_use_RB),
    .ex_WC(ex_WC), .ex_W_RB(ex_W_RB), .ex_S_MXRB(ex_S_MXRB),
    .mem_WC(mem_WC), .mem_W_RB(mem_W_RB), .br_taken(br_taken), .dm_busy(dm_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .fwd_A(fwd_A), .fwd_B(fwd_B),
    .err_timeout(err_timeout), .stall_cnt(stall_cnt)
  );

  function automatic logic [1:0] mfwd(logic [3:0] r, in_t i);
    if (i.ex_w && i.ex_wc == r && i.ex_s != 2'b01) return 2'b01;
    if (i.mem_w && i.mem_wc == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic mlu(in_t i);
    return i.ex_w && i.ex_s == 2'b01 && m_state != 1 &&
           ((i.ua && i.ra == i.ex_wc) || (i.ub && i.rb == i.ex_wc));
  endfunction

  function automatic out_t model_out(in_t i, logic rst);
    out_t o;
    o = '{pc:1'b1, ifid:1'b1, flush:1'b0, idex:1'b1, bubble:1'b0, exmem:1'b1,
          fa:mfwd(i.ra, i), fb:mfwd(i.rb, i), err:m_err, stall:m_stall};
    if (rst) begin
      o.pc = 0; o.ifid = 0; o.idex = 0; o.exmem = 0;
      o.flush = 1; o.bubble = 1; o.fa = 2'b00; o.fb = 2'b00;
    end else if (i.busy) begin
      o.pc = 0; o.ifid = 0; o.idex = 0; o.exmem = 0;
    end else if (i.br) begin
      o.flush = 1; o.bubble = 1;
    end else if (mlu(i)) begin
      o.pc = 0; o.ifid = 0; o.bubble = 1;
    end
    return o;
  endfunction

  task automatic model_clock(in_t i, out_t o);
    logic lu_now;
    lu_now = mlu(i);
    if (!o.pc && m_stall != SAT) m_stall = m_stall + 1'b1;
    if (m_state == 2 && i.busy) begin
      if (m_wait == TIMEOUT) begin
        m_err = 1'b1; m_state = 0; m_wait = 0;
      end else begin
        m_wait = m_wait + 1;
      end
    end else if (i.busy) begin
      m_state = 2; m_wait = 1;
    end else begin
      m_state = (!i.br && lu_now) ? 1 : 0;
      m_wait = 0;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_err = 1'b0; m_stall = '0;
  endtask

  task automatic apply();
    id_RA = cur.ra; id_RB = cur.rb; id_use_RA = cur.ua; id_use_RB = cur.ub;
    ex_WC = cur.ex_wc; ex_W_RB = cur.ex_w; ex_S_MXRB = cur.ex_s;
    mem_WC = cur.mem_wc; mem_W_RB = cur.mem_w; br_taken = cur.br; dm_busy = cur.busy;
  endtask

  task automatic compare_head(string tag);
    out_t got, exp;
    got = '{pc:pc_en, ifid:ifid_en, flush:ifid_flush, idex:idex_en, bubble:idex_bubble,
            exmem:exmem_en, fa:fwd_A, fb:fwd_B, err:err_timeout, stall:stall_cnt};
    exp = sb_q.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(string tag);
    out_t e;
    @(negedge CLK);
    apply();
    e = model_out(cur, RESET);
    sb_q.push_back(e);
    #2;
    compare_head(tag);
    model_clock(cur, e);
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    cur = '0;
  endtask

  task automatic set_load(logic [3:0] wc, logic [3:0] ra);
    idle();
    cur.ex_w = 1; cur.ex_s = 2'b01; cur.ex_wc = wc; cur.ua = 1; cur.ra = ra;
  endtask

  initial begin
    // Reset state: forwarding-positive inputs must still show 00 and flush/bubble.
    idle();
    cur.ex_w = 1; cur.ex_wc = 4'd2; cur.ra = 4'd2; cur.mem_w = 1; cur.mem_wc = 4'd7; cur.rb = 4'd7;
    apply();
    #2;
    model_reset();
    sb_q.push_back(model_out(cur, 1'b1));
    compare_head("reset_outputs");
    @(posedge CLK);
    #1 RESET = 1'b0;

    idle(); step("idle0");
    idle(); step("idle1");

    set_load(4'd3, 4'd3); step("lu_stall");
    step("lu_suppressed");
    idle(); step("after_lu");
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    idle();
    cur.ex_w = 1; cur.ex_s = 2'b00; cur.ex_wc = 4'd5; cur.rb = 4'd5;
    cur.mem_w = 1; cur.mem_wc = 4'd5; cur.ra = 4'd5;
    step("fwd_ex_beats_mem");
    cur.ex_w = 0; step("fwd_mem_only");
    cur.ex_w = 1; cur.ex_s = 2'b01; cur.ua = 0; cur.ub = 0; step("fwd_load_no_ex");
    chk("fwd_B_mem", 32'(fwd_B), 32'd2);

    set_load(4'd0, 4'd0); step("lu_reg0");
    idle(); step("lu_reg0_after");
    idle(); cur.ex_w = 1; cur.ex_s = 2'b01; cur.ex_wc = 4'd9; cur.ub = 1; cur.rb = 4'd9;
    step("lu_rb");
    idle(); step("lu_rb_after");

    set_load(4'd3, 4'd3); cur.br = 1; step("br_with_lu");
    cur.br = 0; step("lu_after_branch");
    idle(); step("idle2");

    base = stall_cnt;
    idle(); cur.busy = 1;
    for (int k = 0; k < 4; k++) step("busy4");
    idle(); step("busy4_resume");
    chk("busy4_stalls", 32'(stall_cnt - base), 32'd4);
    chk("busy4_err", 32'(err_timeout), 32'd0);

    idle(); cur.busy = 1;
    for (int k = 0; k < 15; k++) step("busy20_pre");
    chk("err_before_abort", 32'(err_timeout), 32'd0);
    for (int k = 0; k < 5; k++) step("busy20_post");
    idle(); step("busy20_resume");
    chk("err_sticky", 32'(err_timeout), 32'd1);
    set_load(4'd6, 4'd6); step("lu_after_timeout");
    idle(); step("idle3");

    idle(); cur.busy = 1;
    for (int k = 0; k < 8; k++) step("busy_sat");
    idle(); step("sat_resume");
    chk("stall_saturated", 32'(stall_cnt), 32'(SAT));

    idle(); cur.busy = 1;
    for (int k = 0; k < 3; k++) step("busy_pre_reset");
    @(posedge CLK);
    #3 RESET = 1'b1;
    #1;
    model_reset();
    sb_q.push_back(model_out(cur, 1'b1));
    compare_head("reset_mid_wait");
    @(posedge CLK);
    #1;
    sb_q.push_back(model_out(cur, 1'b1));
    compare_head("reset_held");
    RESET = 1'b0;
    set_load(4'd4, 4'd4); step("post_reset_lu");
    idle(); step("post_reset_idle");
    chk("post_reset_err", 32'(err_timeout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
